// File: rtl/frame_reader_mb.sv
// frame_reader_mb: streams one of NUM_BUFS framebuffers from SDRAM into the pixel FIFO in
// FIFO-level-gated bursts. Optional sticky underrun detector: FRAME_READER_UNDERRUN_DET_EN.
module frame_reader_mb #(
  parameter int ADDR_W      = 22,
  parameter int FRAME_WORDS = 96000,
  parameter int BURST_LEN   = 8,
  parameter int FIFO_DEPTH  = 1024,
  parameter int LOW_THRESH  = 256,
  parameter int NUM_BUFS    = 2,
  parameter int BUF_STRIDE  = 131072,
  localparam int BUF_W  = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1,
  localparam int USED_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Begin,
  input  logic [BUF_W-1:0]  i_Buf_Sel,
  input  logic              i_Data_Read_Valid,
  input  logic [USED_W-1:0] i_Pixel_In_Used,
  input  logic              i_Pixel_Rd,
  input  logic              i_SDRAM_Grant,
  output logic [1:0]        o_Command,
  output logic [ADDR_W-1:0] o_Data_Address,
  output logic              o_FIFO_Wr,
  output logic              o_SDRAM_Request,
  output logic              o_First_Data_Ready,
  output logic              o_Frame_Start,
  output logic [BUF_W-1:0]  o_Active_Buf,
  output logic              o_Underrun
);

  localparam int OFF_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [USED_W-1:0] LOW_T    = USED_W'(LOW_THRESH);
  localparam logic [USED_W-1:0] HIGH_T   = USED_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [OFF_W-1:0]  LAST_OFF = OFF_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    CMD_IDLE = 2'b00,
    CMD_READ = 2'b01
  } cmd_e;

  cmd_e              state_q, state_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              fill_q, fill_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base;
  logic [31:0]       remain, burst_words;
  logic              need, start, wr;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= CMD_IDLE;
      off_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      first_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      first_q <= first_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    need  = (!fill_q && (i_Pixel_In_Used <= LOW_T)) ||
            (fill_q && (i_Pixel_In_Used <= HIGH_T));
    start = (state_q == CMD_IDLE) && i_Begin && i_SDRAM_Grant && need;
    wr    = (state_q == CMD_READ) && i_Data_Read_Valid;

    // The last burst of a frame is clipped so it never runs into the next frame.
    remain      = 32'(FRAME_WORDS) - 32'(off_q);
    burst_words = (remain < 32'(BURST_LEN)) ? remain : 32'(BURST_LEN);

    state_d = state_q;
    off_d   = off_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    first_d = first_q;

    if (fill_q && (i_Pixel_In_Used > HIGH_T)) fill_d = 1'b0;

    case (state_q)
      CMD_IDLE: begin
        if (start) begin
          state_d = CMD_READ;
          fill_d  = 1'b1;
          cnt_d   = 8'(burst_words - 32'd1);
        end
      end
      CMD_READ: begin
        if (wr) begin
          if (off_q == LAST_OFF) begin
            off_d = '0;
            buf_d = i_Buf_Sel;
          end else begin
            off_d = off_q + 1'b1;
          end
          if (cnt_q == 8'd0) begin
            state_d = CMD_IDLE;
            first_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = CMD_IDLE;
    endcase
  end

  // Buffer base as a mux of per-index constants; address tracks the next word.
  always_comb begin
    base = '0;
    for (int k = 0; k < NUM_BUFS; k++) begin
      if (buf_d == BUF_W'(k)) base = ADDR_W'(k * BUF_STRIDE);
    end
    addr_d = base + ADDR_W'(off_d);
  end

  assign o_Command          = state_q;
  assign o_Data_Address     = addr_q;
  assign o_FIFO_Wr          = wr;
  assign o_SDRAM_Request    = need || (state_q != CMD_IDLE);
  assign o_First_Data_Ready = first_q;
  assign o_Frame_Start      = wr && (off_q == '0);
  assign o_Active_Buf       = buf_q;

`ifdef FRAME_READER_UNDERRUN_DET_EN
  logic underrun_q;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      underrun_q <= 1'b0;
    end else if (i_Pixel_Rd && (i_Pixel_In_Used == '0) && first_q) begin
      underrun_q <= 1'b1;
    end
  end

  assign o_Underrun = underrun_q;
`else
  logic unused_pixel_rd;
  assign unused_pixel_rd = i_Pixel_Rd;
  assign o_Underrun      = 1'b0;
`endif

endmodule
